// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch stage and its FIFO.
package ifetch_queue_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [1:0] FETCH_IDLE = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] FETCH_DROP = 2'd2;

  typedef logic [1:0] fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc_4;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Show-ahead FIFO: head is presented combinationally, reads zero when empty.
module ifq_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  parameter int unsigned PtrW  = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [PtrW:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Clear wins over both push and pop; a push is allowed into a full FIFO only if it pops too.
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign do_push = push_i && (!full_o || do_pop) && !clear_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !clear_i && full_o && !do_pop));

endmodule

// File: rtl/ifetch_queue.sv
// Fetch PC, single-outstanding icache request FSM and redirect handling in front of the FIFO.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Dispatch_jmp,
  input  logic [31:0] Dispatch_jmp_addr,
  input  logic        Dispatch_ren,
  output logic [31:0] ifetch_intruction,
  output logic [31:0] ifetch_pc_4,
  output logic        ifetch_empty,
  output logic        icache_rd_en,
  output logic [31:0] icache_addr,
  input  logic        icache_data_valid,
  input  logic [31:0] icache_data
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] pc_plus4;
  logic [PTR_W:0]  fifo_count;
  logic            fifo_full, fifo_empty;
  logic            pop_ok, issue, push;
  ifq_entry_t      push_entry, head_entry;

  assign pc_plus4 = fetch_pc_q + PC_W'(WORD_BYTES);
  assign pop_ok   = Dispatch_ren && !fifo_empty && !Dispatch_jmp;

  // A slot freed by this cycle's pop may be refilled by a request issued in the same cycle.
  assign issue = reset && !Dispatch_jmp && (state_q == FETCH_IDLE) && (!fifo_full || pop_ok);
  assign push  = reset && !Dispatch_jmp && (state_q == FETCH_WAIT) && icache_data_valid;

  assign push_entry.pc_4  = pc_plus4;
  assign push_entry.instr = icache_data;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (Dispatch_jmp) begin
      fetch_pc_d = word_align(Dispatch_jmp_addr);
      case (state_q)
        FETCH_WAIT, FETCH_DROP: state_d = icache_data_valid ? FETCH_IDLE : FETCH_DROP;
        default:                state_d = FETCH_IDLE;
      endcase
    end else begin
      case (state_q)
        FETCH_IDLE: if (issue) state_d = FETCH_WAIT;
        FETCH_WAIT: begin
          if (icache_data_valid) begin
            fetch_pc_d = pc_plus4;
            state_d    = FETCH_IDLE;
          end
        end
        FETCH_DROP: if (icache_data_valid) state_d = FETCH_IDLE;
        default:    state_d = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  ifq_fifo #(
    .Width ($bits(ifq_entry_t)),
    .Depth (DEPTH),
    .PtrW  (PTR_W)
  ) u_fifo (
    .clk_i       (clock),
    .rst_ni      (reset),
    .clear_i     (Dispatch_jmp),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (Dispatch_ren),
    .head_o      (head_entry),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign icache_rd_en      = issue;
  assign icache_addr       = fetch_pc_q;
  assign ifetch_intruction = head_entry.instr;
  assign ifetch_pc_4       = head_entry.pc_4;
  assign ifetch_empty      = fifo_empty;

  a_no_resp_in_idle: assert property (@(posedge clock) disable iff (!reset)
    !(icache_data_valid && (state_q == FETCH_IDLE)));

  a_full_consistent: assert property (@(posedge clock) disable iff (!reset)
    fifo_full == (fifo_count == (PTR_W+1)'(DEPTH)));

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a small 1-cycle icache responder and manual overrides.
module tb_ifetch_queue;

  logic        clock;
  logic        reset;
  logic        Dispatch_jmp;
  logic [31:0] Dispatch_jmp_addr;
  logic        Dispatch_ren;
  logic [31:0] ifetch_intruction;
  logic [31:0] ifetch_pc_4;
  logic        ifetch_empty;
  logic        icache_rd_en;
  logic [31:0] icache_addr;
  logic        icache_data_valid;
  logic [31:0] icache_data;

  logic        auto_en, auto_valid;
  logic [31:0] auto_data;
  logic        man_valid;
  logic [31:0] man_data;
  logic [31:0] req_addr [32];
  int          req_cnt;
  int          total;
  int          bad;

  ifetch_queue #(
    .DEPTH    (4),
    .PTR_W    (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .Dispatch_jmp      (Dispatch_jmp),
    .Dispatch_jmp_addr (Dispatch_jmp_addr),
    .Dispatch_ren      (Dispatch_ren),
    .ifetch_intruction (ifetch_intruction),
    .ifetch_pc_4       (ifetch_pc_4),
    .ifetch_empty      (ifetch_empty),
    .icache_rd_en      (icache_rd_en),
    .icache_addr       (icache_addr),
    .icache_data_valid (icache_data_valid),
    .icache_data       (icache_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cache model: answers addr/4 one cycle after a request while auto_en is set.
  always @(posedge clock) begin
    auto_valid <= auto_en && icache_rd_en;
    auto_data  <= icache_addr >> 2;
    if (icache_rd_en) begin
      if (req_cnt < 32) req_addr[req_cnt] <= icache_addr;
      req_cnt <= req_cnt + 1;
    end
  end

  assign icache_data_valid = auto_valid | man_valid;
  assign icache_data       = man_valid ? man_data : auto_data;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    req_cnt = 0;
    auto_valid = 1'b0;
    auto_data = '0;
    auto_en = 1'b1;
    man_valid = 1'b0;
    man_data = '0;
    reset = 1'b0;
    Dispatch_jmp = 1'b0;
    Dispatch_jmp_addr = '0;
    Dispatch_ren = 1'b0;

    // Reset state
    step(2);
    chk("rst_empty", 32'(ifetch_empty), 32'd1);
    chk("rst_instr", ifetch_intruction, 32'h0);
    chk("rst_pc4", ifetch_pc_4, 32'h0);
    chk("rst_rd_en", 32'(icache_rd_en), 32'd0);
    chk("rst_addr", icache_addr, 32'h0);

    // 1: fill from reset with 1-cycle cache
    reset = 1'b1;
    step(10);
    chk("t1_req_cnt", 32'(req_cnt), 32'd4);
    chk("t1_req0", req_addr[0], 32'h0);
    chk("t1_req1", req_addr[1], 32'h4);
    chk("t1_req2", req_addr[2], 32'h8);
    chk("t1_req3", req_addr[3], 32'hC);
    chk("t1_count", 32'(dut.fifo_count), 32'd4);
    chk("t1_instr", ifetch_intruction, 32'h0);
    chk("t1_pc4", ifetch_pc_4, 32'h4);
    chk("t1_empty", 32'(ifetch_empty), 32'd0);
    chk("t1_rd_en", 32'(icache_rd_en), 32'd0);

    // 2: single pop from full refills exactly once
    Dispatch_ren = 1'b1;
    #1;
    chk("t2_issue", 32'(icache_rd_en), 32'd1);
    chk("t2_addr", icache_addr, 32'h10);
    step(1);
    Dispatch_ren = 1'b0;
    #1;
    chk("t2_instr", ifetch_intruction, 32'h1);
    chk("t2_pc4", ifetch_pc_4, 32'h8);
    chk("t2_count_pop", 32'(dut.fifo_count), 32'd3);
    step(5);
    chk("t2_req_cnt", 32'(req_cnt), 32'd5);
    chk("t2_req4", req_addr[4], 32'h10);
    chk("t2_count", 32'(dut.fifo_count), 32'd4);
    chk("t2_rd_en", 32'(icache_rd_en), 32'd0);

    // 3: redirect during WAIT, stale response 3 cycles later
    auto_en = 1'b0;
    Dispatch_ren = 1'b1;
    step(1);
    Dispatch_ren = 1'b0;
    Dispatch_jmp = 1'b1;
    Dispatch_jmp_addr = 32'h103;
    #1;
    chk("t3_no_issue_jmp", 32'(icache_rd_en), 32'd0);
    step(1);
    Dispatch_jmp = 1'b0;
    #1;
    chk("t3_empty", 32'(ifetch_empty), 32'd1);
    chk("t3_count", 32'(dut.fifo_count), 32'd0);
    chk("t3_no_issue_drop", 32'(icache_rd_en), 32'd0);
    step(2);
    man_valid = 1'b1;
    man_data = 32'hDEAD_BEEF;
    #1;
    chk("t3_no_issue_resp", 32'(icache_rd_en), 32'd0);
    step(1);
    man_valid = 1'b0;
    #1;
    chk("t3_dropped", 32'(ifetch_empty), 32'd1);
    chk("t3_issue", 32'(icache_rd_en), 32'd1);
    chk("t3_addr", icache_addr, 32'h100);
    auto_en = 1'b1;
    step(2);
    chk("t3_vis", 32'(ifetch_empty), 32'd0);
    chk("t3_instr", ifetch_intruction, 32'h40);
    chk("t3_pc4", ifetch_pc_4, 32'h104);
    chk("t3_req6", req_addr[6], 32'h100);
    step(8);

    // 4: redirect together with the response
    auto_en = 1'b0;
    Dispatch_ren = 1'b1;
    step(1);
    Dispatch_ren = 1'b0;
    Dispatch_jmp = 1'b1;
    Dispatch_jmp_addr = 32'h200;
    man_valid = 1'b1;
    man_data = 32'h0000_0BAD;
    step(1);
    Dispatch_jmp = 1'b0;
    man_valid = 1'b0;
    #1;
    chk("t4_empty", 32'(ifetch_empty), 32'd1);
    chk("t4_count", 32'(dut.fifo_count), 32'd0);
    chk("t4_issue", 32'(icache_rd_en), 32'd1);
    chk("t4_addr", icache_addr, 32'h200);
    auto_en = 1'b1;
    step(2);
    chk("t4_instr", ifetch_intruction, 32'h80);
    chk("t4_pc4", ifetch_pc_4, 32'h204);
    step(8);

    // 5: jump with pop, then pops while empty
    auto_en = 1'b0;
    Dispatch_jmp = 1'b1;
    Dispatch_jmp_addr = 32'h300;
    Dispatch_ren = 1'b1;
    step(1);
    Dispatch_jmp = 1'b0;
    #1;
    chk("t5_empty", 32'(ifetch_empty), 32'd1);
    chk("t5_count", 32'(dut.fifo_count), 32'd0);
    chk("t5_instr0", ifetch_intruction, 32'h0);
    chk("t5_pc4_0", ifetch_pc_4, 32'h0);
    chk("t5_issue", 32'(icache_rd_en), 32'd1);
    chk("t5_addr", icache_addr, 32'h300);
    step(1);
    chk("t5_underflow", 32'(dut.fifo_count), 32'd0);
    man_valid = 1'b1;
    man_data = 32'h55;
    step(1);
    man_valid = 1'b0;
    Dispatch_ren = 1'b0;
    #1;
    chk("t5_count1", 32'(dut.fifo_count), 32'd1);
    chk("t5_instr", ifetch_intruction, 32'h55);
    chk("t5_pc4", ifetch_pc_4, 32'h304);

    // 6: reset during WAIT, response ignored
    step(1);
    reset = 1'b0;
    step(1);
    man_valid = 1'b1;
    man_data = 32'h77;
    #1;
    chk("t6_rd_en_rst", 32'(icache_rd_en), 32'd0);
    chk("t6_empty_rst", 32'(ifetch_empty), 32'd1);
    chk("t6_addr_rst", icache_addr, 32'h0);
    step(1);
    man_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_ignored", 32'(ifetch_empty), 32'd1);
    chk("t6_count", 32'(dut.fifo_count), 32'd0);
    chk("t6_issue", 32'(icache_rd_en), 32'd1);
    chk("t6_addr", icache_addr, 32'h0);
    auto_en = 1'b1;
    step(2);
    chk("t6_vis", 32'(ifetch_empty), 32'd0);
    chk("t6_instr", ifetch_intruction, 32'h0);
    chk("t6_pc4", ifetch_pc_4, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
